fft_32_integrator: RTL and testbench

Per-bin power integrator directly downstream of the 32-point FFT. It consumes the FFT output stream (I/Q, bin index, last) and computes |X|² per sample. It accumulates power per bin over 2**INTEG_LOG2 consecutive frames and emits one 32-bin integrated power frame per integration period, for detection/threshold logic. It has no backpressure, matching the FFT output.

---
 rtl/dsp_pkg.sv | 8 +
 rtl/fft_32_power.sv | 74 +++++++
 rtl/fft_32_integrator.sv | 197 +++++++++++++++++++
 tb/tb_fft_32_integrator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the 32-point FFT datapath.
// Contents: FFT length, bin index width and the bin index type.
package dsp_pkg;
  localparam int FFT_32_LENGTH      = 32;
  localparam int FFT_32_INDEX_WIDTH = 5;

  typedef logic [FFT_32_INDEX_WIDTH-1:0] fft_32_index_t;
endpackage

// File: rtl/fft_32_power.sv
// Squared-magnitude pipeline for FFT bins: P = i^2 + q^2.
// Three register stages: S1 input capture, S2 squares, S3 sum.
// Index, last and a generic sideband travel alongside the data.
// Ports:
//   Clk, Rst        clock, synchronous active-low reset
//   Input_*         FFT sample stream (valid, i, q, index, last, side)
//   Power_*         power stream, three cycles behind Input_*
module fft_32_power
  import dsp_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 21,
  parameter int SIDE_WIDTH       = 2
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            Input_valid,
  input  logic signed [INPUT_DATA_WIDTH-1:0] Input_i,
  input  logic signed [INPUT_DATA_WIDTH-1:0] Input_q,
  input  logic [FFT_32_INDEX_WIDTH-1:0]   Input_index,
  input  logic                            Input_last,
  input  logic [SIDE_WIDTH-1:0]           Input_side,
  output logic                            Power_valid,
  output logic [2*INPUT_DATA_WIDTH-1:0]   Power_data,
  output logic [FFT_32_INDEX_WIDTH-1:0]   Power_index,
  output logic                            Power_last,
  output logic [SIDE_WIDTH-1:0]           Power_side
);
  localparam int POWER_WIDTH = 2 * INPUT_DATA_WIDTH;
  localparam int TAG_WIDTH   = FFT_32_INDEX_WIDTH + 1 + SIDE_WIDTH;

  logic                               s1_valid;
  logic signed [INPUT_DATA_WIDTH-1:0] s1_i;
  logic signed [INPUT_DATA_WIDTH-1:0] s1_q;
  logic [TAG_WIDTH-1:0]               s1_tag;

  logic                               s2_valid;
  logic signed [POWER_WIDTH-1:0]      s2_sq_i;
  logic signed [POWER_WIDTH-1:0]      s2_sq_q;
  logic [TAG_WIDTH-1:0]               s2_tag;

  logic [TAG_WIDTH-1:0]               s3_tag;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1_valid    <= 1'b0;
      s1_i        <= '0;
      s1_q        <= '0;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      s2_sq_i     <= '0;
      s2_sq_q     <= '0;
      s2_tag      <= '0;
      Power_valid <= 1'b0;
      Power_data  <= '0;
      s3_tag      <= '0;
    end else begin
      s1_valid    <= Input_valid;
      s1_i        <= Input_i;
      s1_q        <= Input_q;
      s1_tag      <= {Input_index, Input_last, Input_side};
      s2_valid    <= s1_valid;
      s2_sq_i     <= s1_i * s1_i;
      s2_sq_q     <= s1_q * s1_q;
      s2_tag      <= s1_tag;
      // Squares are non-negative and each is at most 2^(2W-2), so the
      // unsigned sum always fits in 2W bits.
      Power_valid <= s2_valid;
      Power_data  <= $unsigned(s2_sq_i) + $unsigned(s2_sq_q);
      s3_tag      <= s2_tag;
    end
  end

  assign {Power_index, Power_last, Power_side} = s3_tag;
endmodule

// File: rtl/fft_32_integrator.sv
// Per-bin power integrator behind the 32-point FFT. Accumulates |X|^2 per
// bin over 2**INTEG_LOG2 frames and emits one 32-bin frame per period.
// Ports:
//   Clk, Rst                      clock, synchronous active-low reset
//   Input_valid/i/q/index/last    FFT output stream (no backpressure)
//   Output_valid/data/index/last  integrated power stream, 4 cycles latency
//   Error_sequence                one-cycle pulse on a framing error
//   Output_peak_data/index        peak bin of the integrated frame, valid on
//                                 the Output_last beat (only when
//                                 FFT_32_INTEGRATOR_PEAK_EN is defined)
// Constraint: OUTPUT_DATA_WIDTH <= 2*INPUT_DATA_WIDTH + INTEG_LOG2.
//
// state   | meaning
// ACCUM   | frame_count < max, bins accumulate silently
// EMIT    | frame_count == max, summed bins are driven out
// DISCARD | discard set, outputs suppressed until the next Input_last
module fft_32_integrator
  import dsp_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 21,
  parameter int INTEG_LOG2        = 4,
  parameter int OUTPUT_DATA_WIDTH = 32
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Input_valid,
  input  logic signed [INPUT_DATA_WIDTH-1:0] Input_i,
  input  logic signed [INPUT_DATA_WIDTH-1:0] Input_q,
  input  logic [FFT_32_INDEX_WIDTH-1:0]     Input_index,
  input  logic                              Input_last,
  output logic                              Output_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0]      Output_data,
  output logic [FFT_32_INDEX_WIDTH-1:0]     Output_index,
  output logic                              Output_last,
`ifdef FFT_32_INTEGRATOR_PEAK_EN
  output logic [OUTPUT_DATA_WIDTH-1:0]      Output_peak_data,
  output logic [FFT_32_INDEX_WIDTH-1:0]     Output_peak_index,
`endif
  output logic                              Error_sequence
);
  localparam int POWER_WIDTH = 2 * INPUT_DATA_WIDTH;
  localparam int ACC_WIDTH   = POWER_WIDTH + INTEG_LOG2;
  // Keep the frame counter at least one bit wide so INTEG_LOG2 = 0 works;
  // it then stays at 0 and every frame is both first and final.
  localparam int FC_WIDTH    = (INTEG_LOG2 > 0) ? INTEG_LOG2 : 1;
  localparam logic [FC_WIDTH-1:0] FC_MAX = FC_WIDTH'((1 << INTEG_LOG2) - 1);
  localparam fft_32_index_t LAST_SAMPLE = fft_32_index_t'(FFT_32_LENGTH - 1);

  fft_32_index_t         sample_count;
  logic [FC_WIDTH-1:0]   frame_count;
  logic                  discard;
  logic                  err_last;
  logic                  err_nolast;
  logic                  first_frame;
  logic                  emit_frame;

  // Framing is judged on the raw input so the error pulse lands one cycle
  // after the offending sample; the per-sample decisions (overwrite/emit)
  // then ride down the power pipeline as sideband bits.
  always_comb begin
    err_last    = Input_valid && Input_last && (sample_count != LAST_SAMPLE);
    err_nolast  = Input_valid && !Input_last && (sample_count == LAST_SAMPLE);
    first_frame = (frame_count == '0);
    emit_frame  = (frame_count == FC_MAX) && !discard && !err_last && !err_nolast;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sample_count   <= '0;
      frame_count    <= '0;
      discard        <= 1'b0;
      Error_sequence <= 1'b0;
    end else begin
      Error_sequence <= err_last || err_nolast;
      if (Input_valid) begin
        if (Input_last) begin
          sample_count <= '0;
          // A short frame or a pending discard abandons the integration;
          // the next frame restarts at frame 0 and overwrites the bins.
          if (err_last || discard) begin
            frame_count <= '0;
            discard     <= 1'b0;
          end else if (frame_count == FC_MAX) begin
            frame_count <= '0;
          end else begin
            frame_count <= frame_count + 1'b1;
          end
        end else if (err_nolast) begin
          sample_count <= '0;
          discard      <= 1'b1;
        end else begin
          sample_count <= sample_count + 1'b1;
        end
      end
    end
  end

  logic                         p_valid;
  logic [POWER_WIDTH-1:0]       p_data;
  fft_32_index_t                p_index;
  logic                         p_last;
  logic                         p_first;
  logic                         p_emit;

  fft_32_power #(
    .INPUT_DATA_WIDTH (INPUT_DATA_WIDTH),
    .SIDE_WIDTH       (2)
  ) u_power (
    .Clk         (Clk),
    .Rst         (Rst),
    .Input_valid (Input_valid),
    .Input_i     (Input_i),
    .Input_q     (Input_q),
    .Input_index (Input_index),
    .Input_last  (Input_last),
    .Input_side  ({first_frame, emit_frame}),
    .Power_valid (p_valid),
    .Power_data  (p_data),
    .Power_index (p_index),
    .Power_last  (p_last),
    .Power_side  ({p_first, p_emit})
  );

  // S4: single-cycle read-modify-write, so back-to-back or repeated
  // indices always see the previous write.
  logic [ACC_WIDTH-1:0]         acc_mem [FFT_32_LENGTH];
  logic [ACC_WIDTH-1:0]         acc_sum;
  logic [OUTPUT_DATA_WIDTH-1:0] acc_trunc;

  always_comb begin
    acc_sum   = p_first ? ACC_WIDTH'(p_data) : acc_mem[p_index] + ACC_WIDTH'(p_data);
    acc_trunc = acc_sum[ACC_WIDTH-1 -: OUTPUT_DATA_WIDTH];
  end

  // Frame 0 overwrites, so the array needs no reset or clear pass.
  always_ff @(posedge Clk) begin
    if (p_valid) begin
      acc_mem[p_index] <= acc_sum;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Output_valid <= 1'b0;
      Output_data  <= '0;
      Output_index <= '0;
      Output_last  <= 1'b0;
    end else begin
      Output_valid <= p_valid && p_emit;
      Output_last  <= p_valid && p_emit && p_last;
      if (p_valid && p_emit) begin
        Output_data  <= acc_trunc;
        Output_index <= p_index;
      end
    end
  end

`ifdef FFT_32_INTEGRATOR_PEAK_EN
  logic [OUTPUT_DATA_WIDTH-1:0] peak_run;
  fft_32_index_t                peak_run_index;
  logic                         peak_fresh;
  logic                         peak_take;
  logic [OUTPUT_DATA_WIDTH-1:0] peak_next;
  fft_32_index_t                peak_next_index;

  // Strict compare keeps the earliest bin on ties.
  always_comb begin
    peak_take       = peak_fresh || (acc_trunc > peak_run);
    peak_next       = peak_take ? acc_trunc : peak_run;
    peak_next_index = peak_take ? p_index : peak_run_index;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      peak_run          <= '0;
      peak_run_index    <= '0;
      peak_fresh        <= 1'b1;
      Output_peak_data  <= '0;
      Output_peak_index <= '0;
    end else if (p_valid) begin
      // Any frame end restarts tracking, so a frame cut short by an error
      // cannot leak into the next emitted frame.
      if (p_last) begin
        peak_fresh <= 1'b1;
        if (p_emit) begin
          Output_peak_data  <= peak_next;
          Output_peak_index <= peak_next_index;
        end
      end else if (p_emit) begin
        peak_run       <= peak_next;
        peak_run_index <= peak_next_index;
        peak_fresh     <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fft_32_integrator.sv
module tb_fft_32_integrator;
  localparam int IDW = 21;
  localparam int IL  = 2;
  localparam int OW  = 44;

  logic                  Clk = 1'b0;
  logic                  Rst = 1'b0;
  logic                  Input_valid = 1'b0;
  logic signed [IDW-1:0] Input_i = '0;
  logic signed [IDW-1:0] Input_q = '0;
  logic [4:0]            Input_index = '0;
  logic                  Input_last = 1'b0;
  logic                  Output_valid;
  logic [OW-1:0]         Output_data;
  logic [4:0]            Output_index;
  logic                  Output_last;
  logic                  Error_sequence;
`ifdef FFT_32_INTEGRATOR_PEAK_EN
  logic [OW-1:0]         Output_peak_data;
  logic [4:0]            Output_peak_index;
`endif

  fft_32_integrator #(
    .INPUT_DATA_WIDTH  (IDW),
    .INTEG_LOG2        (IL),
    .OUTPUT_DATA_WIDTH (OW)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .Input_valid       (Input_valid),
    .Input_i           (Input_i),
    .Input_q           (Input_q),
    .Input_index       (Input_index),
    .Input_last        (Input_last),
    .Output_valid      (Output_valid),
    .Output_data       (Output_data),
    .Output_index      (Output_index),
    .Output_last       (Output_last),
`ifdef FFT_32_INTEGRATOR_PEAK_EN
    .Output_peak_data  (Output_peak_data),
    .Output_peak_index (Output_peak_index),
`endif
    .Error_sequence    (Error_sequence)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic [4:0]    idx;
    logic          last;
    int            cyc;
    logic [OW-1:0] pk_d;
    logic [4:0]    pk_i;
  } exp_t;

  exp_t                  sb[$];
  exp_t                  e;
  int                    n_assert = 0;
  int                    n_fail   = 0;
  int                    err_cyc  = -1;
  bit                    mon_en   = 1'b0;
  logic signed [IDW-1:0] fi[32];
  logic signed [IDW-1:0] fq[32];
  logic [63:0]           ref_acc[32];
  logic [OW-1:0]         pk_d;
  logic [4:0]            pk_i;
  bit                    pk_fresh = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] sq(input logic signed [IDW-1:0] x);
    longint t;
    t = x;
    return t * t;
  endfunction

  task automatic idle(input int n);
    Input_valid = 1'b0;
    Input_last  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic drive(input logic [4:0] idx, input bit lst, input bit emit, input bit err);
    logic [OW-1:0] v;
    Input_valid = 1'b1;
    Input_i     = fi[idx];
    Input_q     = fq[idx];
    Input_index = idx;
    Input_last  = lst;
    ref_acc[idx] = ref_acc[idx] + sq(fi[idx]) + sq(fq[idx]);
    if (err) err_cyc = cyc + 1;
    if (emit) begin
      v = ref_acc[idx][OW-1:0];
      if (pk_fresh || v > pk_d) begin
        pk_d = v;
        pk_i = idx;
      end
      pk_fresh = lst;
      sb.push_back('{v, idx, lst, cyc + 4, pk_d, pk_i});
    end
    @(posedge Clk); #1;
  endtask

  task automatic send_frame(input int n, input int last_pos, input int err_pos,
                            input bit emit, input bit rev, input int gap);
    logic [4:0] idx;
    for (int k = 0; k < n; k++) begin
      idx = rev ? 5'(31 - k) : 5'(k);
      drive(idx, k == last_pos, emit, k == err_pos);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic ref_clear();
    for (int k = 0; k < 32; k++) ref_acc[k] = '0;
    pk_fresh = 1'b1;
  endtask

  task automatic zero_bins();
    for (int k = 0; k < 32; k++) begin
      fi[k] = '0;
      fq[k] = '0;
    end
  endtask

  task automatic integrate(input bit rev, input int gap);
    ref_clear();
    for (int f = 0; f < 4; f++) send_frame(32, 31, -1, f == 3, rev, gap);
  endtask

  task automatic drain(input string tag);
    idle(1);
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    check(tag, sb.size(), 0);
  endtask

  // Output monitor / scoreboard consumer
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (mon_en) begin
        check("error_seq", Error_sequence, cyc == err_cyc);
        if (Output_valid) begin
          check("expected_output", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_data", Output_data, e.data);
            check("out_index", Output_index, e.idx);
            check("out_last", Output_last, e.last);
            check("out_cycle", cyc, e.cyc);
`ifdef FFT_32_INTEGRATOR_PEAK_EN
            if (e.last) begin
              check("peak_data", Output_peak_data, e.pk_d);
              check("peak_index", Output_peak_index, e.pk_i);
            end
`endif
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    zero_bins();
    ref_clear();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_valid", Output_valid, 0);
    check("rst_data", Output_data, 0);
    check("rst_index", Output_index, 0);
    check("rst_last", Output_last, 0);
    check("rst_error", Error_sequence, 0);
`ifdef FFT_32_INTEGRATOR_PEAK_EN
    check("rst_peak_data", Output_peak_data, 0);
    check("rst_peak_index", Output_peak_index, 0);
`endif
    Rst    = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Basic integration: bin 3 = (100, -50) -> 4 * 12500 = 50000
    zero_bins();
    fi[3] = 21'sd100;
    fq[3] = -21'sd50;
    integrate(1'b0, 0);
    drain("basic_drain");

    // Framing error: 31-sample frame ending with last, then 4 good frames
    zero_bins();
    fi[5] = 21'sd1;
    fq[5] = 21'sd1;
    ref_clear();
    send_frame(31, 30, 30, 1'b0, 1'b0, 0);
    idle(3);
    integrate(1'b0, 1);
    drain("short_frame_drain");

    // Missing last: good frame, 32 samples without last, a discarded
    // frame, then a fresh integration of 4 frames (reverse bin order)
    ref_clear();
    send_frame(32, 31, -1, 1'b0, 1'b0, 0);
    send_frame(32, -1, 31, 1'b0, 1'b0, 0);
    send_frame(32, 31, -1, 1'b0, 1'b0, 0);
    integrate(1'b1, 0);
    drain("discard_drain");

    // Full scale, zero-gap frames: every bin 4 * 2^41 = 2^43
    for (int k = 0; k < 32; k++) begin
      fi[k] = -21'sd1048576;
      fq[k] = -21'sd1048576;
    end
    integrate(1'b0, 0);
    drain("full_scale_drain");

    // Mid-integration reset after 2 frames of a large value
    zero_bins();
    fi[9] = 21'sd1000;
    fq[9] = 21'sd1000;
    ref_clear();
    send_frame(32, 31, -1, 1'b0, 1'b0, 0);
    send_frame(32, 31, -1, 1'b0, 1'b0, 0);
    idle(5);
    Rst = 1'b0;
    idle(2);
    check("midrst_valid", Output_valid, 0);
    check("midrst_data", Output_data, 0);
    check("midrst_index", Output_index, 0);
    check("midrst_last", Output_last, 0);
    check("midrst_error", Error_sequence, 0);
    Rst = 1'b1;
    fi[9] = 21'sd3;
    fq[9] = 21'sd4;
    integrate(1'b1, 0);
    drain("post_reset_drain");

    // Peak patterns: tie between bins 7 and 20, then bin 20 larger
    zero_bins();
    fi[7]  = 21'sd10;
    fi[20] = 21'sd10;
    integrate(1'b0, 0);
    drain("peak_tie_drain");
    fi[20] = 21'sd11;
    integrate(1'b0, 0);
    drain("peak_max_drain");

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
